axil_cmd_master: RTL and testbench
==================================

AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1023, is the number of stalled bus cycles before the timeout flag is raised; the legal range is 1 to 65535.
REQ-002 Port clk, input, 1 bit: the single clock; all ports are synchronous to its rising edge.
REQ-003 Port aresetn, input, 1 bit: synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 Ports cmd_tvalid (input, 1), cmd_tready (output, 1), cmd_write (input, 1; 1 = write), cmd_addr (input, 8) and cmd_wdata (input, 32) form the command stream.
REQ-005 Ports rsp_tvalid (output, 1), rsp_tready (input, 1), rsp_write (output, 1), rsp_resp (output, 2) and rsp_rdata (output, 32) form the response stream.
REQ-006 Ports control_awaddr (out, 8), control_awvalid (out), control_awready (in), control_wdata (out, 32), control_wstrb (out, 4), control_wvalid (out) and control_wready (in) form the AXI4-Lite write address and write data channels.
REQ-007 Ports control_bresp (in, 2), control_bvalid (in) and control_bready (out) form the AXI4-Lite write response channel.
REQ-008 Ports control_araddr (out, 8), control_arvalid (out), control_arready (in), control_rdata (in, 32), control_rresp (in, 2), control_rvalid (in) and control_rready (out) form the AXI4-Lite read channels.
REQ-009 Port timeout_err, output, 1 bit: sticky flag set when a bus phase stalls for TIMEOUT_CYCLES cycles.

Function
REQ-010 The state machine SHALL have the states IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA and RSP.
REQ-011 cmd_tready SHALL be 1 only in IDLE; a command is accepted on a cycle where cmd_tvalid and cmd_tready are both 1, and its write bit, address and data SHALL be registered at that edge.
REQ-012 An accepted write SHALL move to WR_ADDR_DATA, and control_awvalid and control_wvalid SHALL both be 1 in the next cycle.
REQ-013 An accepted read SHALL move to RD_ADDR, and control_arvalid SHALL be 1 in the next cycle.
REQ-014 In WR_ADDR_DATA, each of awvalid and wvalid SHALL drop in the cycle after its own handshake, independently of the other channel; the AW and W handshakes may occur in either order or in the same cycle.
REQ-015 The transition to WR_RESP SHALL occur on the edge where the last outstanding AW or W handshake completes.
REQ-016 control_bready SHALL be 1 only in WR_RESP.
REQ-017 On a B handshake, bresp SHALL be captured, rsp_write set to 1, rsp_rdata set to 0 and the state SHALL move to RSP.
REQ-018 In RD_ADDR, an AR handshake SHALL move the state to RD_DATA; control_rready SHALL be 1 only in RD_DATA.
REQ-019 On an R handshake, rdata and rresp SHALL be captured, rsp_write set to 0 and the state SHALL move to RSP.
REQ-020 rsp_tvalid SHALL be 1 only in RSP, with the rsp_* fields held stable while it is 1; an rsp_tvalid/rsp_tready handshake SHALL return the state to IDLE.
REQ-021 A new command SHALL only be accepted once the state is back in IDLE (one outstanding transaction maximum), so the earliest command acceptance is the cycle after the response handshake.
REQ-022 Once asserted, a valid SHALL never be withdrawn before its handshake, and the address/data/strobe it qualifies SHALL remain stable; control_wstrb SHALL be 4'hF whenever control_wvalid is 1.
REQ-023 Unused read/write address outputs SHALL be driven to 0 outside their phase.
REQ-024 A 16-bit stall counter SHALL clear on every state change and increment by 1 (saturating at 65535) each cycle spent in WR_ADDR_DATA, WR_RESP, RD_ADDR or RD_DATA.
REQ-025 When the counter reaches TIMEOUT_CYCLES, timeout_err SHALL be set to 1 and held until reset.
REQ-026 A timeout SHALL NOT abort the transaction: valids stay asserted and the state machine continues to wait.
REQ-027 A nonzero bresp or rresp SHALL be passed through on rsp_resp unchanged and SHALL NOT affect timeout_err.

Reset
REQ-028 While aresetn is 0 at a rising edge, the state SHALL become IDLE and the stall counter 0.
REQ-029 During and after reset, every valid/ready output, timeout_err, every rsp_* field and all control_* address, data and strobe outputs SHALL be 0.
REQ-030 Reset asserted mid-transaction SHALL drop every valid at the next edge regardless of handshake state; the testbench resets the slave simultaneously.

Verification
REQ-031 Write: cmd{write=1, addr=8'h0C, wdata=32'h0001_0203}, with awready=wready=1 at cycle 1 and bvalid at cycle 2 with bresp=0 -> rsp_tvalid=1 at cycle 3, rsp_write=1, rsp_resp=0, rsp_rdata=0.
REQ-032 Read: cmd{write=0, addr=8'h14}, with arready=1 at cycle 1 and rvalid at cycle 3 with rdata=32'hDEAD_BEEF, rresp=2'b10 -> rsp_rdata=32'hDEAD_BEEF, rsp_resp=2'b10, rsp_write=0.
REQ-033 Split write: wready at cycle 1, awready withheld until cycle 4 -> wvalid low from cycle 2, awvalid held with addr stable through cycle 4, bready first 1 at cycle 5.
REQ-034 Back-pressure: rsp_tready=0 for 5 cycles with a new cmd_tvalid pending -> rsp fields stable and cmd_tready=0 throughout; the command is accepted in the cycle after the response handshake.
REQ-035 Timeout: TIMEOUT_CYCLES=8 and arready held 0 -> timeout_err=1 after exactly 8 cycles in RD_ADDR with arvalid still 1; arready=1 afterwards -> the transaction completes normally and timeout_err stays 1.
REQ-036 Reset mid-operation: aresetn=0 while in WR_RESP -> bready=0 and cmd_tready=0 during reset; after release the next command completes correctly.

Source files
------------

// File: rtl/axil_cmd_master.sv
// Turns a command stream into single AXI4-Lite read/write transactions and returns
// each result on a response stream. At most one transaction is in flight at a time.
module axil_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        cmd_tvalid,
    output logic        cmd_tready,
    input  logic        cmd_write,
    input  logic [7:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_tvalid,
    input  logic        rsp_tready,
    output logic        rsp_write,
    output logic [1:0]  rsp_resp,
    output logic [31:0] rsp_rdata,
    output logic [7:0]  control_awaddr,
    output logic        control_awvalid,
    input  logic        control_awready,
    output logic [31:0] control_wdata,
    output logic [3:0]  control_wstrb,
    output logic        control_wvalid,
    input  logic        control_wready,
    input  logic [1:0]  control_bresp,
    input  logic        control_bvalid,
    output logic        control_bready,
    output logic [7:0]  control_araddr,
    output logic        control_arvalid,
    input  logic        control_arready,
    input  logic [31:0] control_rdata,
    input  logic [1:0]  control_rresp,
    input  logic        control_rvalid,
    output logic        control_rready,
    output logic        timeout_err
);
    typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP} state_t;

    state_t      state, state_nxt;
    logic [7:0]  addr_q;
    logic [31:0] wdata_q;
    logic        aw_pend, w_pend;
    logic        rsp_write_q;
    logic [1:0]  rsp_resp_q;
    logic [31:0] rsp_rdata_q;
    logic [15:0] stall_cnt, stall_inc;
    logic        timeout_q;
    logic        waiting;

    assign waiting   = (state == WR_ADDR_DATA) || (state == WR_RESP) ||
                       (state == RD_ADDR) || (state == RD_DATA);
    assign stall_inc = (stall_cnt == 16'hFFFF) ? stall_cnt : stall_cnt + 16'd1;

    always_comb begin
        state_nxt       = state;
        cmd_tready      = 1'b0;
        control_awvalid = 1'b0;
        control_wvalid  = 1'b0;
        control_bready  = 1'b0;
        control_arvalid = 1'b0;
        control_rready  = 1'b0;
        rsp_tvalid      = 1'b0;
        case (state)
            IDLE: begin
                cmd_tready = 1'b1;
                if (cmd_tvalid) state_nxt = cmd_write ? WR_ADDR_DATA : RD_ADDR;
            end
            WR_ADDR_DATA: begin
                control_awvalid = aw_pend;
                control_wvalid  = w_pend;
                // leave once every still-pending channel handshakes this cycle
                if ((!aw_pend || control_awready) && (!w_pend || control_wready))
                    state_nxt = WR_RESP;
            end
            WR_RESP: begin
                control_bready = 1'b1;
                if (control_bvalid) state_nxt = RSP;
            end
            RD_ADDR: begin
                control_arvalid = 1'b1;
                if (control_arready) state_nxt = RD_DATA;
            end
            RD_DATA: begin
                control_rready = 1'b1;
                if (control_rvalid) state_nxt = RSP;
            end
            RSP: begin
                rsp_tvalid = 1'b1;
                if (rsp_tready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // hold every handshake output low while reset is asserted
        if (!aresetn) begin
            cmd_tready      = 1'b0;
            control_awvalid = 1'b0;
            control_wvalid  = 1'b0;
            control_bready  = 1'b0;
            control_arvalid = 1'b0;
            control_rready  = 1'b0;
            rsp_tvalid      = 1'b0;
        end
    end

    assign control_awaddr = control_awvalid ? addr_q  : 8'h00;
    assign control_wdata  = control_wvalid  ? wdata_q : 32'h0;
    assign control_wstrb  = control_wvalid  ? 4'hF    : 4'h0;
    assign control_araddr = control_arvalid ? addr_q  : 8'h00;
    assign rsp_write      = rsp_write_q;
    assign rsp_resp       = rsp_resp_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign timeout_err    = timeout_q;

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state       <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            aw_pend     <= 1'b0;
            w_pend      <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_resp_q  <= '0;
            rsp_rdata_q <= '0;
            stall_cnt   <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && cmd_tvalid) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                aw_pend <= cmd_write;
                w_pend  <= cmd_write;
            end
            if (state == WR_ADDR_DATA && control_awready) aw_pend <= 1'b0;
            if (state == WR_ADDR_DATA && control_wready)  w_pend  <= 1'b0;
            if (state == WR_RESP && control_bvalid) begin
                rsp_write_q <= 1'b1;
                rsp_resp_q  <= control_bresp;
                rsp_rdata_q <= '0;
            end
            if (state == RD_DATA && control_rvalid) begin
                rsp_write_q <= 1'b0;
                rsp_resp_q  <= control_rresp;
                rsp_rdata_q <= control_rdata;
            end
            if (state_nxt != state)
                stall_cnt <= '0;
            else if (waiting)
                stall_cnt <= stall_inc;
            // flag raised on the edge the count reaches the limit; the transfer keeps waiting
            if (waiting && state_nxt == state && stall_inc == 16'(TIMEOUT_CYCLES))
                timeout_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_axil_cmd_master.sv
// Random and directed bench for axil_cmd_master: a delay-programmable AXI-Lite slave,
// a transaction-level memory model for expected responses, and a protocol monitor.
module tb_axil_cmd_master;
    logic        clk = 1'b0;
    logic        aresetn;
    logic        cmd_tvalid, cmd_tready, cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_tvalid, rsp_tready, rsp_write;
    logic [1:0]  rsp_resp;
    logic [31:0] rsp_rdata;
    logic [7:0]  control_awaddr, control_araddr;
    logic        control_awvalid, control_awready, control_wvalid, control_wready;
    logic [31:0] control_wdata, control_rdata;
    logic [3:0]  control_wstrb;
    logic [1:0]  control_bresp, control_rresp;
    logic        control_bvalid, control_bready, control_arvalid, control_arready;
    logic        control_rvalid, control_rready, timeout_err;

    int n_chk = 0;
    int n_bad = 0;
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [31:0] smem [256];
    logic [31:0] mdl_mem [256];
    logic [1:0]  resp_tab [256];

    always #5 clk = ~clk;

    axil_cmd_master #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .aresetn(aresetn),
        .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_tvalid(rsp_tvalid), .rsp_tready(rsp_tready), .rsp_write(rsp_write),
        .rsp_resp(rsp_resp), .rsp_rdata(rsp_rdata),
        .control_awaddr(control_awaddr), .control_awvalid(control_awvalid),
        .control_awready(control_awready), .control_wdata(control_wdata),
        .control_wstrb(control_wstrb), .control_wvalid(control_wvalid),
        .control_wready(control_wready), .control_bresp(control_bresp),
        .control_bvalid(control_bvalid), .control_bready(control_bready),
        .control_araddr(control_araddr), .control_arvalid(control_arvalid),
        .control_arready(control_arready), .control_rdata(control_rdata),
        .control_rresp(control_rresp), .control_rvalid(control_rvalid),
        .control_rready(control_rready), .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Slave: each ready/valid rises after its trigger has been seen for more than *_dly cycles
    initial begin
        int aw_c, w_c, b_c, ar_c, r_c;
        logic [7:0]  aw_a, ar_a;
        logic [31:0] w_d;
        aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
        aw_a = '0; ar_a = '0; w_d = '0;
        control_awready = 0; control_wready = 0; control_bvalid = 0; control_bresp = 0;
        control_arready = 0; control_rvalid = 0; control_rdata = 0; control_rresp = 0;
        forever begin
            @(negedge clk);
            if (!aresetn) begin
                aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
                control_awready = 0; control_wready = 0; control_bvalid = 0; control_bresp = 0;
                control_arready = 0; control_rvalid = 0; control_rdata = 0; control_rresp = 0;
            end else begin
                aw_c = control_awvalid ? aw_c + 1 : 0;
                control_awready = control_awvalid && (aw_c > aw_dly);
                if (control_awready) aw_a = control_awaddr;
                w_c = control_wvalid ? w_c + 1 : 0;
                control_wready = control_wvalid && (w_c > w_dly);
                if (control_wready) w_d = control_wdata;
                b_c = control_bready ? b_c + 1 : 0;
                control_bvalid = control_bready && (b_c > b_dly);
                control_bresp  = control_bvalid ? resp_tab[aw_a] : 2'b00;
                if (control_bvalid) smem[aw_a] = w_d;
                ar_c = control_arvalid ? ar_c + 1 : 0;
                control_arready = control_arvalid && (ar_c > ar_dly);
                if (control_arready) ar_a = control_araddr;
                r_c = control_rready ? r_c + 1 : 0;
                control_rvalid = control_rready && (r_c > r_dly);
                control_rdata  = control_rvalid ? smem[ar_a] : 32'h0;
                control_rresp  = control_rvalid ? resp_tab[ar_a] : 2'b00;
            end
        end
    end

    // Protocol monitor: stalled valids hold with stable payload; strobes; no accept while busy
    initial begin
        logic pv_aw, pr_aw, pv_w, pr_w, pv_ar, pr_ar, pv_rs, pr_rs;
        logic [7:0]  pa_aw, pa_ar;
        logic [31:0] pd_w;
        logic [34:0] pf_rs;
        pv_aw = 0; pr_aw = 0; pv_w = 0; pr_w = 0; pv_ar = 0; pr_ar = 0; pv_rs = 0; pr_rs = 0;
        pa_aw = 0; pa_ar = 0; pd_w = 0; pf_rs = 0;
        forever begin
            @(negedge clk); #1;
            if (!aresetn) begin
                pv_aw = 0; pv_w = 0; pv_ar = 0; pv_rs = 0;
            end else begin
                if (pv_aw && !pr_aw) chk("aw_hold", {control_awvalid, control_awaddr}, {1'b1, pa_aw});
                if (pv_w && !pr_w)   chk("w_hold", {control_wvalid, control_wdata}, {1'b1, pd_w});
                if (pv_ar && !pr_ar) chk("ar_hold", {control_arvalid, control_araddr}, {1'b1, pa_ar});
                if (pv_rs && !pr_rs)
                    chk("rsp_hold", {rsp_tvalid, rsp_write, rsp_resp, rsp_rdata}, {1'b1, pf_rs});
                if (control_wvalid) chk("wstrb", control_wstrb, 4'hF);
                if (rsp_tvalid) chk("busy_cmd_rdy", cmd_tready, 0);
                pv_aw = control_awvalid; pr_aw = control_awready; pa_aw = control_awaddr;
                pv_w  = control_wvalid;  pr_w  = control_wready;  pd_w  = control_wdata;
                pv_ar = control_arvalid; pr_ar = control_arready; pa_ar = control_araddr;
                pv_rs = rsp_tvalid; pr_rs = rsp_tready; pf_rs = {rsp_write, rsp_resp, rsp_rdata};
            end
        end
    end

    // Presents a command and returns at the negedge of the first cycle after acceptance
    task automatic send_cmd(input logic w, input logic [7:0] a, input logic [31:0] d);
        int n;
        n = 0;
        @(negedge clk);
        cmd_tvalid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        while (!cmd_tready && n < 50) begin @(negedge clk); n++; end
        chk("cmd_accept", cmd_tready, 1);
        @(posedge clk); @(negedge clk);
        cmd_tvalid = 0;
    endtask

    task automatic wait_rsp(input logic ew, input logic [1:0] er, input logic [31:0] ed, input int pct);
        int  n;
        logic done;
        n = 0; done = 0;
        while (!done && n < 200) begin
            rsp_tready = ($urandom_range(99) < pct);
            if (rsp_tvalid && rsp_tready) begin
                chk("rsp_write", rsp_write, ew);
                chk("rsp_resp", rsp_resp, er);
                chk("rsp_rdata", rsp_rdata, ed);
                done = 1;
            end
            @(negedge clk); n++;
        end
        rsp_tready = 0;
        chk("rsp_seen", done, 1);
    endtask

    task automatic do_txn(input logic w, input logic [7:0] a, input logic [31:0] d);
        logic [31:0] exp_d;
        exp_d = w ? 32'h0 : mdl_mem[a];
        send_cmd(w, a, d);
        wait_rsp(w, resp_tab[a], exp_d, 60);
        if (w) mdl_mem[a] = d;
    endtask

    initial begin
        logic [31:0] v;
        aresetn = 0; cmd_tvalid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; rsp_tready = 0;
        for (int i = 0; i < 256; i++) begin
            v = $urandom; smem[i] = v; mdl_mem[i] = v; resp_tab[i] = 2'($urandom_range(3));
        end
        resp_tab[8'h0C] = 2'b00; resp_tab[8'h14] = 2'b10;
        smem[8'h14] = 32'hDEAD_BEEF; mdl_mem[8'h14] = 32'hDEAD_BEEF;

        repeat (3) @(negedge clk);
        chk("rst_cmd_tready", cmd_tready, 0);
        chk("rst_valids", {rsp_tvalid, control_awvalid, control_wvalid, control_arvalid}, 0);
        chk("rst_readies", {control_bready, control_rready}, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_rsp", {rsp_write, rsp_resp, rsp_rdata}, 0);
        chk("rst_addr", {control_awaddr, control_araddr, control_wdata, control_wstrb}, 0);
        aresetn = 1;
        @(negedge clk);
        chk("idle_cmd_tready", cmd_tready, 1);

        // basic write, all slave readies immediate
        send_cmd(1, 8'h0C, 32'h0001_0203);
        chk("wr_c1_valids", {control_awvalid, control_wvalid}, 2'b11);
        chk("wr_c1_payload", {control_awaddr, control_wdata, control_wstrb}, {8'h0C, 32'h0001_0203, 4'hF});
        @(negedge clk);
        chk("wr_c2_bready", control_bready, 1);
        @(negedge clk);
        chk("wr_c3_rsp", {rsp_tvalid, rsp_write, rsp_resp, rsp_rdata}, {1'b1, 1'b1, 2'b00, 32'h0});
        wait_rsp(1, 2'b00, 32'h0, 100);
        mdl_mem[8'h0C] = 32'h0001_0203;

        // read with error response, rvalid one cycle late
        r_dly = 1;
        send_cmd(0, 8'h14, 32'h0);
        chk("rd_c1_ar", {control_arvalid, control_araddr}, {1'b1, 8'h14});
        @(negedge clk);
        chk("rd_c2_rready", control_rready, 1);
        wait_rsp(0, 2'b10, 32'hDEAD_BEEF, 100);
        r_dly = 0;

        // split write: W at cycle 1, AW at cycle 4
        aw_dly = 3;
        send_cmd(1, 8'h20, 32'h1234_5678);
        chk("sp_c1", {control_awvalid, control_wvalid}, 2'b11);
        @(negedge clk);
        chk("sp_c2", {control_awvalid, control_wvalid, control_awaddr}, {2'b10, 8'h20});
        @(negedge clk);
        chk("sp_c3", {control_awvalid, control_bready}, 2'b10);
        @(negedge clk);
        chk("sp_c4", {control_awvalid, control_awaddr, control_bready}, {1'b1, 8'h20, 1'b0});
        @(negedge clk);
        chk("sp_c5", {control_awvalid, control_bready}, 2'b01);
        wait_rsp(1, resp_tab[8'h20], 32'h0, 100);
        mdl_mem[8'h20] = 32'h1234_5678;
        aw_dly = 0;

        // response back-pressure with the next command already waiting
        send_cmd(1, 8'h40, 32'hA5A5_0F0F);
        cmd_tvalid = 1; cmd_write = 0; cmd_addr = 8'h40; cmd_wdata = 0;
        for (int i = 0; i < 20 && !rsp_tvalid; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", {rsp_tvalid, cmd_tready, rsp_write, rsp_resp, rsp_rdata},
                {1'b1, 1'b0, 1'b1, resp_tab[8'h40], 32'h0});
            @(negedge clk);
        end
        rsp_tready = 1;
        chk("bp_hs_cmd_rdy", cmd_tready, 0);
        @(posedge clk); @(negedge clk);
        rsp_tready = 0;
        chk("bp_next_cmd_rdy", cmd_tready, 1);
        @(posedge clk); @(negedge clk);
        cmd_tvalid = 0;
        chk("bp_next_ar", {cmd_tready, control_arvalid, control_araddr}, {2'b01, 8'h40});
        mdl_mem[8'h40] = 32'hA5A5_0F0F;
        wait_rsp(0, resp_tab[8'h40], 32'hA5A5_0F0F, 100);

        // random traffic over a small address window so reads hit earlier writes
        for (int t = 0; t < 150; t++) begin
            aw_dly = $urandom_range(3); w_dly = $urandom_range(3); b_dly = $urandom_range(3);
            ar_dly = $urandom_range(3); r_dly = $urandom_range(3);
            do_txn(1'($urandom_range(1)), 8'($urandom_range(31)), $urandom);
        end
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
        chk("no_timeout_yet", timeout_err, 0);

        // timeout after 8 stalled cycles in RD_ADDR; transfer still completes
        ar_dly = 1000;
        send_cmd(0, 8'h08, 32'h0);
        for (int k = 1; k < 8; k++) @(negedge clk);
        chk("to_before", timeout_err, 0);
        @(negedge clk);
        chk("to_set", {timeout_err, control_arvalid}, 2'b11);
        ar_dly = 0;
        wait_rsp(0, resp_tab[8'h08], mdl_mem[8'h08], 100);
        chk("to_sticky", timeout_err, 1);

        // reset while waiting in WR_RESP
        b_dly = 5;
        send_cmd(1, 8'h30, 32'hCAFE_0000);
        @(negedge clk);
        chk("mr_bready", control_bready, 1);
        @(negedge clk);
        aresetn = 0;
        #1;
        chk("mr_during", {control_bready, cmd_tready}, 2'b00);
        @(negedge clk);
        chk("mr_after_edge", {timeout_err, rsp_tvalid, control_bready, cmd_tready}, 0);
        chk("mr_rsp_clr", {rsp_write, rsp_resp, rsp_rdata}, 0);
        @(negedge clk);
        aresetn = 1; b_dly = 0;
        do_txn(0, 8'h30, 32'h0);
        do_txn(1, 8'h30, 32'h0BAD_F00D);
        do_txn(0, 8'h30, 32'h0);
        chk("mr_timeout_clr", timeout_err, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end
endmodule
